rmt_ingress_arbiter: RTL and testbench

RMT_INGRESS_ARBITER -- requirements
Module: rmt_ingress_arbiter

---
 rtl/rmt_ingress_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_rmt_ingress_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ingress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rmt_ingress_arbiter
//  Purpose  : Packet-granular 2:1 AXI-Stream arbiter in front of the RMT
//             pipeline. Port 0 carries configuration packets and has strict
//             priority. Port 1 carries data packets. A packet, once started,
//             owns the output until its tlast is accepted. After every config
//             packet the data port is held off for CFG_QUIESCE_CYCLES cycles
//             so that reconfiguration settles before traffic resumes.
//  Ports    :
//    clk, aresetn                 clock / asynchronous active-low reset
//    s_cfg_axis_*                 config packet stream in  (port 0)
//    s_dat_axis_*                 data packet stream in    (port 1)
//    m_axis_*                     merged stream out to the RMT pipeline
//    cfg_pkt_cnt, dat_pkt_cnt     forwarded packet counters (wrapping)
//    busy                         packet locked or quiesce running
//  Revision : 1.0 - initial release
// ============================================================================
module rmt_ingress_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CFG_QUIESCE_CYCLES   = 16
) (
  input  logic                              clk,
  input  logic                              aresetn,

  // Config stream (port 0)
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_cfg_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_cfg_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_cfg_axis_tuser,
  input  logic                              s_cfg_axis_tvalid,
  input  logic                              s_cfg_axis_tlast,
  output logic                              s_cfg_axis_tready,

  // Data stream (port 1)
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_dat_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_dat_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_dat_axis_tuser,
  input  logic                              s_dat_axis_tvalid,
  input  logic                              s_dat_axis_tlast,
  output logic                              s_dat_axis_tready,

  // Merged output stream
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  // Status
  output logic [31:0]                       cfg_pkt_cnt,
  output logic [31:0]                       dat_pkt_cnt,
  output logic                              busy
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOCK_CFG = 2'd1;
  localparam logic [1:0] LOCK_DAT = 2'd2;
  localparam logic [1:0] QUIESCE  = 2'd3;

  localparam logic [7:0] QUIESCE_LOAD = 8'(CFG_QUIESCE_CYCLES);

  // With no hold-off configured, a finished config packet returns straight
  // to arbitration instead of spending a cycle in QUIESCE.
  localparam logic [1:0] POST_CFG = (CFG_QUIESCE_CYCLES == 0) ? IDLE : QUIESCE;

  logic [1:0] state;
  logic [1:0] next_state;
  logic [7:0] quiesce_cnt;

  logic       grant_cfg;
  logic       grant_dat;

  logic       cfg_beat;
  logic       dat_beat;
  logic       cfg_done;
  logic       dat_done;

  // --------------------------------------------------------------------------
  // Process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cfg_beat) begin
          next_state = s_cfg_axis_tlast ? POST_CFG : LOCK_CFG;
        end else if (dat_beat) begin
          next_state = s_dat_axis_tlast ? IDLE : LOCK_DAT;
        end
      end
      LOCK_CFG: begin
        if (cfg_done) begin
          next_state = POST_CFG;
        end
      end
      LOCK_DAT: begin
        if (dat_done) begin
          next_state = IDLE;
        end
      end
      QUIESCE: begin
        // A new config packet may start during hold-off; its tlast reloads
        // the counter. Otherwise leave once the last blocking cycle is spent.
        if (cfg_beat) begin
          next_state = s_cfg_axis_tlast ? POST_CFG : LOCK_CFG;
        end else if (quiesce_cnt <= 8'd1) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: output decode (grant and busy)
  // --------------------------------------------------------------------------
  // Grant is Mealy in IDLE/QUIESCE so the first beat of a packet passes in
  // the cycle it is presented. Grants are forced off while reset is held so
  // no handshake can be signalled to either source during reset.
  always_comb begin
    grant_cfg = 1'b0;
    grant_dat = 1'b0;
    busy      = (state != IDLE);
    if (aresetn) begin
      case (state)
        IDLE: begin
          if (s_cfg_axis_tvalid) begin
            grant_cfg = 1'b1;
          end else if (s_dat_axis_tvalid) begin
            grant_dat = 1'b1;
          end
        end
        LOCK_CFG: grant_cfg = 1'b1;
        LOCK_DAT: grant_dat = 1'b1;
        QUIESCE:  grant_cfg = s_cfg_axis_tvalid;
        default: begin
          grant_cfg = 1'b0;
          grant_dat = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Zero-latency datapath mux
  // --------------------------------------------------------------------------
  assign s_cfg_axis_tready = grant_cfg & m_axis_tready;
  assign s_dat_axis_tready = grant_dat & m_axis_tready;

  assign m_axis_tvalid = (grant_cfg & s_cfg_axis_tvalid) |
                         (grant_dat & s_dat_axis_tvalid);

  assign m_axis_tdata  = grant_cfg ? s_cfg_axis_tdata :
                         grant_dat ? s_dat_axis_tdata : '0;
  assign m_axis_tkeep  = grant_cfg ? s_cfg_axis_tkeep :
                         grant_dat ? s_dat_axis_tkeep : '0;
  assign m_axis_tuser  = grant_cfg ? s_cfg_axis_tuser :
                         grant_dat ? s_dat_axis_tuser : '0;
  assign m_axis_tlast  = grant_cfg ? s_cfg_axis_tlast :
                         grant_dat ? s_dat_axis_tlast : 1'b0;

  // Accepted beats seen at the granted source
  assign cfg_beat = s_cfg_axis_tvalid & s_cfg_axis_tready;
  assign dat_beat = s_dat_axis_tvalid & s_dat_axis_tready;
  assign cfg_done = cfg_beat & s_cfg_axis_tlast;
  assign dat_done = dat_beat & s_dat_axis_tlast;

  // --------------------------------------------------------------------------
  // Quiesce counter: loaded on each config tlast, counts down one per
  // QUIESCE cycle, and is parked at zero everywhere else.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      quiesce_cnt <= 8'd0;
    end else if (cfg_done) begin
      quiesce_cnt <= QUIESCE_LOAD;
    end else if (state == QUIESCE) begin
      if (quiesce_cnt != 8'd0) begin
        quiesce_cnt <= quiesce_cnt - 8'd1;
      end
    end else begin
      quiesce_cnt <= 8'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarded-packet counters, free-running and wrapping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_pkt_cnt <= 32'd0;
      dat_pkt_cnt <= 32'd0;
    end else begin
      if (cfg_done) begin
        cfg_pkt_cnt <= cfg_pkt_cnt + 32'd1;
      end
      if (dat_done) begin
        dat_pkt_cnt <= dat_pkt_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmt_ingress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rmt_ingress_arbiter
//  Purpose  : Self-checking bench for rmt_ingress_arbiter. Expected output
//             beats are queued in the order they must appear on m_axis and
//             popped as the DUT hands them off. A second instance with
//             CFG_QUIESCE_CYCLES = 0 shares the stimulus for the hold-off
//             boundary case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rmt_ingress_arbiter;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [DW-1:0] s_cfg_axis_tdata, s_dat_axis_tdata;
  logic [KW-1:0] s_cfg_axis_tkeep, s_dat_axis_tkeep;
  logic [UW-1:0] s_cfg_axis_tuser, s_dat_axis_tuser;
  logic          s_cfg_axis_tvalid, s_cfg_axis_tlast, s_cfg_axis_tready;
  logic          s_dat_axis_tvalid, s_dat_axis_tlast, s_dat_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]   cfg_pkt_cnt, dat_pkt_cnt;
  logic          busy;

  // Outputs of the zero-quiesce instance
  logic          z_cfg_tready, z_dat_tready;
  logic [DW-1:0] z_tdata;
  logic [KW-1:0] z_tkeep;
  logic [UW-1:0] z_tuser;
  logic          z_tvalid, z_tlast, z_busy;
  logic [31:0]   z_cfg_cnt, z_dat_cnt;

  rmt_ingress_arbiter dut (
    .clk(clk), .aresetn(aresetn),
    .s_cfg_axis_tdata(s_cfg_axis_tdata), .s_cfg_axis_tkeep(s_cfg_axis_tkeep),
    .s_cfg_axis_tuser(s_cfg_axis_tuser), .s_cfg_axis_tvalid(s_cfg_axis_tvalid),
    .s_cfg_axis_tlast(s_cfg_axis_tlast), .s_cfg_axis_tready(s_cfg_axis_tready),
    .s_dat_axis_tdata(s_dat_axis_tdata), .s_dat_axis_tkeep(s_dat_axis_tkeep),
    .s_dat_axis_tuser(s_dat_axis_tuser), .s_dat_axis_tvalid(s_dat_axis_tvalid),
    .s_dat_axis_tlast(s_dat_axis_tlast), .s_dat_axis_tready(s_dat_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cfg_pkt_cnt(cfg_pkt_cnt), .dat_pkt_cnt(dat_pkt_cnt), .busy(busy)
  );

  rmt_ingress_arbiter #(.CFG_QUIESCE_CYCLES(0)) dut0 (
    .clk(clk), .aresetn(aresetn),
    .s_cfg_axis_tdata(s_cfg_axis_tdata), .s_cfg_axis_tkeep(s_cfg_axis_tkeep),
    .s_cfg_axis_tuser(s_cfg_axis_tuser), .s_cfg_axis_tvalid(s_cfg_axis_tvalid),
    .s_cfg_axis_tlast(s_cfg_axis_tlast), .s_cfg_axis_tready(z_cfg_tready),
    .s_dat_axis_tdata(s_dat_axis_tdata), .s_dat_axis_tkeep(s_dat_axis_tkeep),
    .s_dat_axis_tuser(s_dat_axis_tuser), .s_dat_axis_tvalid(s_dat_axis_tvalid),
    .s_dat_axis_tlast(s_dat_axis_tlast), .s_dat_axis_tready(z_dat_tready),
    .m_axis_tdata(z_tdata), .m_axis_tkeep(z_tkeep),
    .m_axis_tuser(z_tuser), .m_axis_tvalid(z_tvalid),
    .m_axis_tlast(z_tlast), .m_axis_tready(m_axis_tready),
    .cfg_pkt_cnt(z_cfg_cnt), .dat_pkt_cnt(z_dat_cnt), .busy(z_busy)
  );

  typedef struct {
    logic          port;   // 0 = config, 1 = data
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t   sb_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      hs_count = 0;
  int      busy_cycles = 0;
  longint  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t make_beat(input bit port, input int n, input int base, input int i);
    beat_t b;
    b.port = port;
    b.data = {16{32'(base * 16 + i)}};
    b.keep = (i == n - 1 && n > 1) ? 64'h00000000000fffff : {KW{1'b1}};
    b.user = {4{32'(base + 1000 * i)}};
    b.last = (i == n - 1);
    return b;
  endfunction

  function automatic void push_pkt(input bit port, input int n, input int base);
    for (int i = 0; i < n; i++) sb_q.push_back(make_beat(port, n, base, i));
  endfunction

  task automatic drive(input bit port, input bit v, input beat_t b);
    if (port) begin
      s_dat_axis_tvalid = v; s_dat_axis_tdata = b.data; s_dat_axis_tkeep = b.keep;
      s_dat_axis_tuser = b.user; s_dat_axis_tlast = b.last & v;
    end else begin
      s_cfg_axis_tvalid = v; s_cfg_axis_tdata = b.data; s_cfg_axis_tkeep = b.keep;
      s_cfg_axis_tuser = b.user; s_cfg_axis_tlast = b.last & v;
    end
  endtask

  task automatic drive_idle(input bit port);
    beat_t b;
    b = make_beat(port, 1, 0, 0);
    drive(port, 1'b0, b);
  endtask

  // Presents one packet beat by beat, holding each beat until its handshake.
  // Records the cycle numbers of the first and last accepted beat.
  task automatic send_pkt(input bit port, input int n, input int base, input bit bubble,
                          output longint first_c, output longint last_c);
    beat_t b;
    bit    hs;
    int    wait_c;
    first_c = -1;
    last_c  = -1;
    for (int i = 0; i < n; i++) begin
      b = make_beat(port, n, base, i);
      drive(port, 1'b1, b);
      wait_c = 0;
      hs = 1'b0;
      while (!hs && wait_c < 200) begin
        @(negedge clk);
        hs = port ? s_dat_axis_tready : s_cfg_axis_tready;
        if (hs) begin
          if (i == 0) first_c = cyc;
          last_c = cyc;
        end
        @(posedge clk); #1;
        wait_c++;
      end
      if (!hs) begin
        check(port ? "dat_handshake_timeout" : "cfg_handshake_timeout", 0, 1);
        break;
      end
      if (bubble && i < n - 1) begin
        drive_idle(port);
        @(posedge clk); #1;
      end
    end
    drive_idle(port);
  endtask

  // Output monitor: every accepted m_axis beat must match the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (busy) busy_cycles++;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("sb_port", s_dat_axis_tready, e.port);
        check("sb_data", m_axis_tdata, e.data);
        check("sb_keep", m_axis_tkeep, e.keep);
        check("sb_user", m_axis_tuser, e.user);
        check("sb_last", m_axis_tlast, e.last);
      end
    end
  end

  task automatic do_reset();
    check("sb_drained", sb_q.size(), 0);
    aresetn = 1'b0;
    drive_idle(1'b0);
    drive_idle(1'b1);
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  longint cf, cl, df, dl, t0;
  int     h0, nblk;
  beat_t  bb, b2;

  initial begin
    aresetn = 1'b0;
    m_axis_tready = 1'b1;
    drive_idle(1'b0);
    drive_idle(1'b1);
    s_cfg_axis_tvalid = 1'b1;
    s_dat_axis_tvalid = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_cfg_tready", s_cfg_axis_tready, 0);
    check("rst_dat_tready", s_dat_axis_tready, 0);
    check("rst_cfg_cnt", cfg_pkt_cnt, 0);
    check("rst_dat_cnt", dat_pkt_cnt, 0);
    do_reset();

    // Data-only 2-beat packet
    push_pkt(1'b1, 2, 1);
    busy_cycles = 0;
    t0 = cyc;
    send_pkt(1'b1, 2, 1, 1'b0, df, dl);
    @(negedge clk);
    check("t1_zero_latency", df - t0, 0);
    check("t1_back_to_back", dl - df, 1);
    check("t1_dat_cnt", dat_pkt_cnt, 1);
    check("t1_busy_cycles", busy_cycles, 1);
    check("t1_busy_after", busy, 0);
    @(posedge clk); #1;
    do_reset();

    // Contention: config wins, data waits out the hold-off
    push_pkt(1'b0, 2, 2);
    push_pkt(1'b1, 2, 3);
    fork
      send_pkt(1'b0, 2, 2, 1'b0, cf, cl);
      send_pkt(1'b1, 2, 3, 1'b0, df, dl);
    join
    @(negedge clk);
    check("t2_dat_after_quiesce", df - cl, 17);
    check("t2_cfg_cnt", cfg_pkt_cnt, 1);
    check("t2_dat_cnt", dat_pkt_cnt, 1);
    @(posedge clk); #1;
    do_reset();

    // No interleave: config arrives during a locked data packet
    push_pkt(1'b1, 3, 4);
    push_pkt(1'b0, 2, 5);
    fork
      send_pkt(1'b1, 3, 4, 1'b0, df, dl);
      begin
        @(posedge clk); #1;
        send_pkt(1'b0, 2, 5, 1'b0, cf, cl);
      end
    join
    @(negedge clk);
    check("t3_cfg_follows", cf - dl, 1);
    check("t3_cfg_cnt", cfg_pkt_cnt, 1);
    check("t3_dat_cnt", dat_pkt_cnt, 1);
    @(posedge clk); #1;
    do_reset();

    // Backpressure 1,0,0,1 during a 3-beat config packet
    push_pkt(1'b0, 3, 6);
    h0 = hs_count;
    bb = make_beat(1'b0, 3, 6, 1);
    fork
      send_pkt(1'b0, 3, 6, 1'b0, cf, cl);
      begin
        @(posedge clk); #1 m_axis_tready = 1'b0;
        @(negedge clk);
        check("t4_stall1_data", m_axis_tdata, bb.data);
        check("t4_stall1_valid", m_axis_tvalid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_stall2_data", m_axis_tdata, bb.data);
        @(posedge clk); #1 m_axis_tready = 1'b1;
      end
    join
    @(negedge clk);
    check("t4_handshakes", hs_count - h0, 3);
    check("t4_cfg_cnt", cfg_pkt_cnt, 1);
    @(posedge clk); #1;
    do_reset();

    // Bubble inside a locked data packet keeps the lock
    push_pkt(1'b1, 3, 7);
    push_pkt(1'b0, 1, 8);
    fork
      send_pkt(1'b1, 3, 7, 1'b1, df, dl);
      begin
        @(posedge clk); #1;
        send_pkt(1'b0, 1, 8, 1'b0, cf, cl);
      end
    join
    @(negedge clk);
    check("t5_cfg_after_bubble_pkt", cf - dl, 1);
    check("t5_dat_cnt", dat_pkt_cnt, 1);
    @(posedge clk); #1;
    do_reset();

    // Quiesce edge: zero hold-off vs default 16
    push_pkt(1'b0, 1, 9);
    push_pkt(1'b1, 1, 10);
    bb = make_beat(1'b0, 1, 9, 0);
    b2 = make_beat(1'b1, 1, 10, 0);
    drive(1'b0, 1'b1, bb);
    @(negedge clk);
    check("t6_cfg_tready", s_cfg_axis_tready, 1);
    check("t6_q0_cfg_tready", z_cfg_tready, 1);
    @(posedge clk); #1;
    drive_idle(1'b0);
    drive(1'b1, 1'b1, b2);
    @(negedge clk);
    check("t6_q0_dat_grant", z_dat_tready, 1);
    check("t6_q0_m_tvalid", z_tvalid, 1);
    check("t6_q0_cfg_cnt", z_cfg_cnt, 1);
    check("t6_q16_dat_blocked", s_dat_axis_tready, 0);
    nblk = 1;
    while (!s_dat_axis_tready && nblk < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      nblk++;
    end
    check("t6_q16_grant_cycle", nblk, 17);
    @(posedge clk); #1;
    drive_idle(1'b1);
    @(negedge clk);
    check("t6_cfg_cnt", cfg_pkt_cnt, 1);
    check("t6_dat_cnt", dat_pkt_cnt, 1);
    @(posedge clk); #1;
    do_reset();

    // Reset in the middle of a data packet
    push_pkt(1'b1, 1, 12);
    send_pkt(1'b1, 1, 12, 1'b0, df, dl);
    sb_q.push_back(make_beat(1'b1, 3, 11, 0));
    bb = make_beat(1'b1, 3, 11, 0);
    drive(1'b1, 1'b1, bb);
    @(negedge clk);
    check("t7_beat0_tready", s_dat_axis_tready, 1);
    @(posedge clk); #1;
    bb = make_beat(1'b1, 3, 11, 1);
    drive(1'b1, 1'b1, bb);
    #2 aresetn = 1'b0;
    #1;
    check("t7_rst_dat_cnt", dat_pkt_cnt, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_m_tvalid", m_axis_tvalid, 0);
    check("t7_rst_dat_tready", s_dat_axis_tready, 0);
    @(posedge clk); #1;
    drive_idle(1'b1);
    aresetn = 1'b1;
    push_pkt(1'b0, 2, 13);
    send_pkt(1'b0, 2, 13, 1'b0, cf, cl);
    @(negedge clk);
    check("t7_cfg_cnt", cfg_pkt_cnt, 1);
    check("t7_dat_cnt", dat_pkt_cnt, 0);
    check("t7_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
